wb_pad_in: RTL and testbench

//  Wishbone classic slave for input pads; the input-side counterpart of the pad-output path.
//  - Synchronises NUM_PADS asynchronous pad inputs and debounces each one.
//  - Exposes the pad levels as registers.
//  - Raises a level interrupt on selected rising/falling edges; irq_o feeds a simple_pic_w irq line.

---
 rtl/wb_pad_in.sv | 145 ++++++++++++++
 tb/tb_wb_pad_in.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pad_in.sv
// Wishbone classic slave for input pads: per-pad two-flop synchroniser, debounce,
// edge-status capture and a registered level interrupt.

module wb_pad_in_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rstn,
    input  logic pad,
    output logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    // flip marks the edge where the debounced level takes the synchronised value
    assign flip = (sync2 != deb) && (cnt == CNT_LAST);
    assign raw  = sync2;
    assign rise = flip & sync2;
    assign fall = flip & ~sync2;

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pad;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (flip) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module wb_pad_in #(
    parameter int NUM_PADS        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WB_ADDR_WIDTH   = 32
) (
    input  logic                     clk_i,
    input  logic                     rstn,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]              wb_dat_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic [31:0]              wb_dat_o,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    input  logic [NUM_PADS-1:0]      pad_i,
    output logic                     irq_o
);
    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_RAW  = 3'd1;
    localparam logic [2:0] A_IEN  = 3'd2;
    localparam logic [2:0] A_RISE = 3'd3;
    localparam logic [2:0] A_FALL = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;

    logic [NUM_PADS-1:0] raw, deb, rise_ev, fall_ev, wmask;
    logic [NUM_PADS-1:0] ien, rise_en, fall_en, stat;
    logic [NUM_PADS-1:0] wdata, stat_set, stat_clr;
    logic [2:0]          addr;
    logic                acc, wr;
    logic [31:0]         rdata;
    logic                unused_bits;

    wb_pad_in_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane [NUM_PADS-1:0] (
        .clk_i (clk_i),
        .rstn  (rstn),
        .pad   (pad_i),
        .raw   (raw),
        .deb   (deb),
        .rise  (rise_ev),
        .fall  (fall_ev)
    );

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_mask
        assign wmask[i] = wb_sel_i[i/8];
    end

    assign addr        = wb_adr_i[4:2];
    assign acc         = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr          = acc & wb_we_i;
    assign wdata       = wb_dat_i[NUM_PADS-1:0];
    assign wb_err_o    = 1'b0;
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

    // a new edge on the same clock as a W1C of that bit keeps the bit set
    assign stat_set = (rise_ev & rise_en) | (fall_ev & fall_en);
    assign stat_clr = (wr && addr == A_STAT) ? (wdata & wmask) : '0;

    always_comb begin
        rdata = '0;
        case (addr)
            A_DATA:  rdata = 32'(deb);
            A_RAW:   rdata = 32'(raw);
            A_IEN:   rdata = 32'(ien);
            A_RISE:  rdata = 32'(rise_en);
            A_FALL:  rdata = 32'(fall_en);
            A_STAT:  rdata = 32'(stat);
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ien      <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            stat     <= '0;
            irq_o    <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            if (acc) wb_dat_o <= rdata;
            if (wr) begin
                case (addr)
                    A_IEN:   ien     <= (ien     & ~wmask) | (wdata & wmask);
                    A_RISE:  rise_en <= (rise_en & ~wmask) | (wdata & wmask);
                    A_FALL:  fall_en <= (fall_en & ~wmask) | (wdata & wmask);
                    default: ;
                endcase
            end
            stat  <= (stat & ~stat_clr) | stat_set;
            irq_o <= |(stat & ien);
        end
    end
endmodule

// File: tb/tb_wb_pad_in.sv
// Directed bench for wb_pad_in: a 4-pad instance for behaviour, a 12-pad instance
// sharing the bus for byte-lane masking.

module tb_wb_pad_in;
    logic        clk_i = 1'b0;
    logic        rstn  = 1'b0;
    logic [31:0] adr   = '0;
    logic [31:0] wdat  = '0;
    logic [3:0]  sel   = '0;
    logic        we    = 1'b0;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic [3:0]  pad   = '0;
    logic [11:0] pad12 = '0;
    logic [31:0] dat_o, dat12;
    logic        ack, ack12, err, err12, irq, irq12;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    wb_pad_in #(.NUM_PADS(4), .DEBOUNCE_CYCLES(16), .WB_ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rstn(rstn), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .pad_i(pad), .irq_o(irq)
    );

    wb_pad_in #(.NUM_PADS(12), .DEBOUNCE_CYCLES(16), .WB_ADDR_WIDTH(32)) dut12 (
        .clk_i(clk_i), .rstn(rstn), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat12), .wb_ack_o(ack12),
        .wb_err_o(err12), .pad_i(pad12), .irq_o(irq12)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Bus access: returns data from both instances and the ack latency; adds one idle clock.
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r4,
                           output logic [31:0] r12, output int lat);
        adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!ack && lat < 8);
        n_chk++;
        if (!ack) begin
            n_fail++;
            $display("FAIL ack_timeout adr=%h: no ack within %0d clocks", a, lat);
        end
        r4 = dat_o; r12 = dat12;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r4);
        logic [31:0] r12; int lat;
        wb_xfer(1'b0, a, '0, 4'hF, r4, r12, lat);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r4, r12; int lat;
        wb_xfer(1'b1, a, d, 4'hF, r4, r12, lat);
    endtask

    task automatic test_reset();
        logic [31:0] r4, r12; int lat;
        rstn = 1'b0; pad = '0;
        tick(3);
        n_chk++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat got %h want 0", dat_o); end
        n_chk++; if (ack !== 1'b0)    begin n_fail++; $display("FAIL rst_ack got %b want 0", ack); end
        n_chk++; if (irq !== 1'b0)    begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
        n_chk++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err got %b want 0", err); end
        rstn = 1'b1;
        wb_xfer(1'b1, 32'h18, 32'hFFFF_FFFF, 4'hF, r4, r12, lat);
        for (int i = 0; i < 8; i++) begin
            wb_xfer(1'b0, 32'(i * 4), '0, 4'hF, r4, r12, lat);
            n_chk++; if (r4 !== 32'h0) begin n_fail++; $display("FAIL rst_read[%0d] got %h want 0", i, r4); end
            n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL rst_ack_lat[%0d] got %0d want 1", i, lat); end
            n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_pulse[%0d] got %b want 0", i, ack); end
        end
    endtask

    task automatic test_debounce();
        logic [31:0] r;
        wr(32'h08, 32'h1);
        wr(32'h0C, 32'h1);
        pad[0] = 1'b1;                   // first sampling edge k = next edge
        rd(32'h04, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL raw_early got %h want 0", r); end
        rd(32'h04, r);
        n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL raw_2clk got %h want 1", r); end
        tick(12);
        rd(32'h00, r);                   // samples state after k+15
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL data_early got %h want 0", r); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_k17 got %b want 0", irq); end
        tick(1);
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_k18 got %b want 1", irq); end
        rd(32'h00, r);
        n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL data_set got %h want 1", r); end
        rd(32'h14, r);
        n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL stat_rise0 got %h want 1", r); end
        wr(32'h14, 32'h1);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr0 got %b want 0", irq); end
        // glitch shorter than the debounce window
        wr(32'h0C, 32'h3);
        pad[1] = 1'b1;
        tick(10);
        pad[1] = 1'b0;
        tick(20);
        rd(32'h00, r);
        n_chk++; if (r !== 32'h1) begin n_fail++; $display("FAIL glitch_data got %h want 1", r); end
        rd(32'h14, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL glitch_stat got %h want 0", r); end
    endtask

    task automatic test_edge_irq();
        logic [31:0] r;
        wr(32'h08, 32'h4);
        wr(32'h0C, 32'h4);
        wr(32'h10, 32'h0);
        pad[2] = 1'b1;
        tick(18);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq2_early got %b want 0", irq); end
        tick(1);
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq2_set got %b want 1", irq); end
        rd(32'h14, r);
        n_chk++; if (r !== 32'h4) begin n_fail++; $display("FAIL stat2_rise got %h want 4", r); end
        wr(32'h14, 32'h4);
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq2_clr got %b want 0", irq); end
        rd(32'h14, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL stat2_clr got %h want 0", r); end
        pad[2] = 1'b0;
        tick(25);
        rd(32'h14, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL stat2_fall got %h want 0", r); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq2_fall got %b want 0", irq); end
    endtask

    task automatic test_collision();
        logic [31:0] r;
        wr(32'h08, 32'h8);
        wr(32'h0C, 32'h8);
        wr(32'h10, 32'h8);
        pad[3] = 1'b1;
        tick(25);
        rd(32'h14, r);
        n_chk++; if (r !== 32'h8) begin n_fail++; $display("FAIL stat3_rise got %h want 8", r); end
        pad[3] = 1'b0;                   // falling flip lands 18 edges from here
        tick(17);
        wr(32'h14, 32'h8);               // ack edge coincides with the flip
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq3_keep got %b want 1", irq); end
        rd(32'h14, r);
        n_chk++; if (r !== 32'h8) begin n_fail++; $display("FAIL stat3_collide got %h want 8", r); end
        wr(32'h14, 32'h8);
        rd(32'h14, r);
        n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL stat3_clr got %h want 0", r); end
    endtask

    task automatic test_bytesel();
        logic [31:0] r4, r12; int lat;
        wb_xfer(1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0001, r4, r12, lat);
        wb_xfer(1'b0, 32'h08, '0, 4'hF, r4, r12, lat);
        n_chk++; if (r12 !== 32'h0000_00FF) begin n_fail++; $display("FAIL bsel12_lo got %h want 000000ff", r12); end
        n_chk++; if (r4 !== 32'h0000_000F) begin n_fail++; $display("FAIL bsel4_lo got %h want 0000000f", r4); end
        wb_xfer(1'b1, 32'h08, 32'h0000_0A00, 4'b0010, r4, r12, lat);
        wb_xfer(1'b0, 32'h08, '0, 4'hF, r4, r12, lat);
        n_chk++; if (r12 !== 32'h0000_0AFF) begin n_fail++; $display("FAIL bsel12_hi got %h want 00000aff", r12); end
        // strobe withdrawn before the clock edge
        adr = 32'h08; wdat = 32'h0; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        #3 stb = 1'b0;
        tick(1);
        n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b want 0", ack); end
        cyc = 1'b0; we = 1'b0;
        tick(1);
        wb_xfer(1'b0, 32'h08, '0, 4'hF, r4, r12, lat);
        n_chk++; if (r12 !== 32'h0000_0AFF) begin n_fail++; $display("FAIL abort_nowr got %h want 00000aff", r12); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r;
        wr(32'h14, 32'hFFFF_FFFF);
        wr(32'h08, 32'h3);
        wr(32'h0C, 32'h3);
        wr(32'h10, 32'h3);
        pad[0] = 1'b0;                   // pad0 falls, pad1 rises
        pad[1] = 1'b1;
        tick(25);
        rd(32'h14, r);
        n_chk++; if (r !== 32'h3) begin n_fail++; $display("FAIL pre_rst_stat got %h want 3", r); end
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_rst_irq got %b want 1", irq); end
        pad[2] = 1'b1;
        tick(8);
        rstn = 1'b0;
        tick(2);
        n_chk++; if (dat_o !== 32'h0) begin n_fail++; $display("FAIL mid_rst_dat got %h want 0", dat_o); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_rst_irq got %b want 0", irq); end
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) continue;        // RAW legitimately follows the held pads
            rd(32'(i * 4), r);
            n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL post_rst_reg[%0d] got %h want 0", i, r); end
        end
        wr(32'h0C, 32'hF);
        tick(20);
        rd(32'h14, r);
        n_chk++; if (r !== 32'h6) begin n_fail++; $display("FAIL post_rst_rise got %h want 6", r); end
        rd(32'h00, r);
        n_chk++; if (r !== 32'h6) begin n_fail++; $display("FAIL post_rst_data got %h want 6", r); end
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL post_rst_irq got %b want 0", irq); end
    endtask

    initial begin
        #1;
        test_reset();
        test_debounce();
        test_edge_irq();
        test_collision();
        test_bytesel();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
